interrupt_sequencer: RTL and testbench
======================================

// Module: interrupt_sequencer
// PURPOSE
//  Front end of the CPU interrupt path. Synchronises the NMI/IRQ pins and edge-detects NMI.
//  Drives the set/clear vectors of the 3-bit pending-interrupt sc_latch {IRQ,NMI,RES} and reads its value back.
//  At an instruction boundary it runs the 7-cycle BRK/IRQ/NMI/RESET sequence: opcode injection, push control, vector select.
// PARAMETERS
//  P_sync_stages  2  flops per pin synchroniser (min 2)
//  P_seq_len      7  cycles in the interrupt sequence (cycle index 0..P_seq_len-1)
// PORTS
//  I_clock        in   1  system clock (all logic on posedge)
//  I_reset        in   1  asynchronous, active-low reset
//  I_nmi_n        in   1  NMI pin, async, active low
//  I_irq_n        in   1  IRQ pin, async, active low, level
//  I_ready        in   1  RDY; 0 freezes sequence counter and outputs
//  I_sync         in   1  opcode-fetch cycle strobe (instruction boundary)
//  I_brk          in   1  fetched opcode decodes as BRK (valid with I_sync)
//  I_flag_i       in   1  P.I interrupt-disable flag
//  I_pending      in   3  pending latch value {IRQ,NMI,RES}
//  O_latch_set    out  3  set vector to pending latch
//  O_latch_clear  out  3  clear vector to pending latch
//  O_inject       out  1  force opcode 8'h00 into IR (hardware interrupt)
//  O_busy         out  1  sequence in progress
//  O_seq_cycle    out  3  current sequence cycle
//  O_push_n       out  1  0 = stack push is a real write (cycles 2..4); 1 during RESET
//  O_b_flag       out  1  B bit value for pushed P (1 only for BRK)
//  O_set_i        out  1  one-cycle pulse at cycle 4: set P.I
//  O_vector_lo    out  8  vector low byte: FA NMI, FC RES, FE IRQ/BRK; valid cycles 5..6
// BEHAVIOUR
//  Reset values: all outputs 0 except O_push_n=1 and O_vector_lo=8'hFE. State IDLE. Synchronisers are all-ones.
//  First cycle after reset release: O_latch_set=3'b001 (RES) for exactly one cycle.
//  NMI: a 1->0 on the synchronised pin gives O_latch_set[1]=1 for one cycle. A held-low pin never re-sets it.
//   Latency is pin fall to set pulse = P_sync_stages+1 clocks.
//  IRQ: O_latch_set[2] = synced IRQ low & ~I_flag_i; O_latch_clear[2] = synced IRQ high. This is level-tracking.
//  Set and clear on the same bit are never driven in the same cycle.
//  FSM states:
//   IDLE  -> SEQ when I_sync & I_ready & (|I_pending | I_brk).
//            O_inject=1 in the entry cycle iff |I_pending. A pending interrupt outranks BRK.
//   SEQ   -> counter 0..P_seq_len-1, advancing only when I_ready=1. Returns to IDLE after the last cycle.
//  Priority at entry: RES > NMI > IRQ > BRK. The source is latched and held in a 2-bit register.
//  O_b_flag=1 only when the source is BRK. O_push_n=1 for the whole sequence when the source is RES.
//  Cycle 6 (last): O_latch_clear pulses the serviced bit. BRK clears nothing.
//  I_ready low: all strobes (O_set_i, O_latch_clear) are held off until the cycle completes with I_ready=1.
//  A new NMI edge during a sequence is still latched as pending. It is serviced at the next boundary, subject to NMI_HIJACK_EN.
//  I_reset asserted mid-sequence: immediate return to IDLE with reset values, then RES set on release.
// CONFIGURATION
//  NMI_HIJACK_EN defined: if I_pending[1] rises while the source is IRQ/BRK and cycle<=3, the source switches to NMI.
//   O_vector_lo becomes FA, O_b_flag is unchanged (BRK still pushes B=1), and the cycle-6 clear targets NMI.
//  NMI_HIJACK_EN undefined: source is frozen at entry; the NMI waits for the next boundary.
// STRUCTURE
//  Package cpu_irq_pkg:
//   typedef enum {IDLE,SEQ} irq_state_t
//   typedef enum logic[1:0] {SRC_RES,SRC_NMI,SRC_IRQ,SRC_BRK} irq_src_t
//   localparams VEC_NMI=8'hFA, VEC_RES=8'hFC, VEC_IRQ=8'hFE
//   localparams IDX_RES=0, IDX_NMI=1, IDX_IRQ=2
//  Sub-module: pin_synchronizer (P_sync_stages flops, async-reset to 1). Instantiated twice.
// TESTING
//  1. Release reset, I_sync=1 at cycle 3 -> latch_set=001 at cycle 1; SEQ, O_push_n=1 throughout, vector FC, clear=001 at seq cycle 6.
//  2. I_nmi_n falls and held low 50 cycles -> exactly one latch_set=010 pulse at +3 clocks; vector FA; no second sequence.
//  3. I_irq_n low with I_flag_i=1 -> no set; drop I_flag_i -> set=100, sequence pushes B=0, O_set_i at cycle 4, vector FE.
//  4. BRK at boundary, NMI pending at seq cycle 2 -> with NMI_HIJACK_EN vector FA, B=1; without, vector FE then NMI sequence next.
//  5. I_ready=0 for 3 cycles at seq cycle 4 -> O_seq_cycle holds 4, O_set_i fires once after RDY returns.
//  6. I_reset low at seq cycle 3 -> outputs at reset values asynchronously; RES sequence follows release.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
// Shared types, vector constants and helpers for the CPU interrupt sequencer.
package cpu_irq_pkg;

    typedef enum logic {IDLE, SEQ} irq_state_t;

    typedef enum logic [1:0] {SRC_RES, SRC_NMI, SRC_IRQ, SRC_BRK} irq_src_t;

    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RES = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    localparam int IDX_RES = 0;
    localparam int IDX_NMI = 1;
    localparam int IDX_IRQ = 2;

    // Fixed priority RES > NMI > IRQ; with nothing pending the entry came from BRK.
    function automatic irq_src_t pick_source(input logic [2:0] pending);
        if (pending[IDX_RES]) return SRC_RES;
        if (pending[IDX_NMI]) return SRC_NMI;
        if (pending[IDX_IRQ]) return SRC_IRQ;
        return SRC_BRK;
    endfunction

    function automatic logic [7:0] vector_of(input irq_src_t src);
        case (src)
            SRC_NMI: return VEC_NMI;
            SRC_RES: return VEC_RES;
            default: return VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pending-latch bus between the interrupt sequencer (master) and the 3-bit {IRQ,NMI,RES} sc_latch (slave).
interface interrupt_sequencer_if;

    logic [2:0] I_pending;
    logic [2:0] O_latch_set;
    logic [2:0] O_latch_clear;

    modport master (
        input  I_pending,
        output O_latch_set,
        output O_latch_clear
    );

    modport slave (
        output I_pending,
        input  O_latch_set,
        input  O_latch_clear
    );

endinterface

// File: rtl/interrupt_sequencer_sync.sv
// pin_synchronizer: P_sync_stages-deep flop chain (minimum 2) for an async active-low pin; resets to idle-high.
module pin_synchronizer #(
    parameter int P_sync_stages = 2
) (
    input  logic I_clock,
    input  logic I_reset,
    input  logic I_pin,
    output logic O_sync
);

    logic [P_sync_stages-1:0] stages;

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            stages <= '1;
        end else begin
            stages <= {stages[P_sync_stages-2:0], I_pin};
        end
    end

    assign O_sync = stages[P_sync_stages-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt front end: pin sync, NMI edge detect, pending-latch set/clear and the 7-cycle BRK/IRQ/NMI/RES sequence.
// Optional NMI_HIJACK_EN: a late NMI may take over an IRQ/BRK sequence up to cycle 3.
module interrupt_sequencer
    import cpu_irq_pkg::*;
#(
    parameter int P_sync_stages = 2,
    parameter int P_seq_len     = 7
) (
    input  logic                  I_clock,
    input  logic                  I_reset,
    input  logic                  I_nmi_n,
    input  logic                  I_irq_n,
    input  logic                  I_ready,
    input  logic                  I_sync,
    input  logic                  I_brk,
    input  logic                  I_flag_i,
    interrupt_sequencer_if.master latch,
    output logic                  O_inject,
    output logic                  O_busy,
    output logic [2:0]            O_seq_cycle,
    output logic                  O_push_n,
    output logic                  O_b_flag,
    output logic                  O_set_i,
    output logic [7:0]            O_vector_lo
);

    localparam logic [2:0] SEQ_LAST = 3'(P_seq_len - 1);

    logic       nmi_sync;
    logic       irq_sync;
    logic       alive_q;
    logic       nmi_prev_q;
    logic [2:0] set_q;
    logic       clr_irq_q;
    logic [2:0] svc_clr;

    irq_state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    irq_src_t   src_q, src_d;
    logic       brk_q, brk_d;

    pin_synchronizer #(.P_sync_stages(P_sync_stages)) u_nmi_sync (
        .I_clock (I_clock),
        .I_reset (I_reset),
        .I_pin   (I_nmi_n),
        .O_sync  (nmi_sync)
    );

    pin_synchronizer #(.P_sync_stages(P_sync_stages)) u_irq_sync (
        .I_clock (I_clock),
        .I_reset (I_reset),
        .I_pin   (I_irq_n),
        .O_sync  (irq_sync)
    );

    // Latch drive: RES on the first cycle out of reset, NMI on a falling edge, IRQ tracks the level.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            alive_q    <= 1'b0;
            nmi_prev_q <= 1'b1;
            set_q      <= '0;
            clr_irq_q  <= 1'b0;
        end else begin
            alive_q         <= 1'b1;
            nmi_prev_q      <= nmi_sync;
            set_q[IDX_RES]  <= ~alive_q;
            set_q[IDX_NMI]  <= nmi_prev_q & ~nmi_sync;
            set_q[IDX_IRQ]  <= ~irq_sync & ~I_flag_i;
            clr_irq_q       <= irq_sync;
        end
    end

    // A fresh set in the clear cycle wins, so a new request is never lost to the service acknowledge.
    always_comb begin
        svc_clr = '0;
        if (state_q == SEQ && cnt_q == SEQ_LAST && I_ready) begin
            case (src_q)
                SRC_RES: svc_clr[IDX_RES] = 1'b1;
                SRC_NMI: svc_clr[IDX_NMI] = 1'b1;
                SRC_IRQ: svc_clr[IDX_IRQ] = 1'b1;
                default: svc_clr = '0;
            endcase
        end
    end

    assign latch.O_latch_set   = set_q;
    assign latch.O_latch_clear = {clr_irq_q, 2'b00} | (svc_clr & ~set_q);

`ifdef NMI_HIJACK_EN
    logic nmi_pend_q;
    logic nmi_rise;

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_pend_q <= latch.I_pending[IDX_NMI];
        end
    end

    assign nmi_rise = latch.I_pending[IDX_NMI] & ~nmi_pend_q;
`endif

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= SRC_RES;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        brk_d       = brk_q;
        O_inject    = 1'b0;
        O_busy      = 1'b0;
        O_seq_cycle = cnt_q;
        O_push_n    = 1'b1;
        O_b_flag    = 1'b0;
        O_set_i     = 1'b0;
        O_vector_lo = VEC_IRQ;

        case (state_q)
            IDLE: begin
                if (alive_q && I_sync && I_ready && ((|latch.I_pending) || I_brk)) begin
                    O_inject = |latch.I_pending;
                    state_d  = SEQ;
                    cnt_d    = '0;
                    src_d    = pick_source(latch.I_pending);
                    brk_d    = ~(|latch.I_pending);
                end
            end
            SEQ: begin
                O_busy      = 1'b1;
                O_push_n    = ~((src_q != SRC_RES) && (cnt_q >= 3'd2) && (cnt_q <= 3'd4));
                O_b_flag    = brk_q;
                O_set_i     = (cnt_q == 3'd4) && I_ready;
                O_vector_lo = vector_of(src_q);
`ifdef NMI_HIJACK_EN
                // B is carried in brk_q, so a hijacked BRK still pushes B=1.
                if (nmi_rise && (src_q == SRC_IRQ || src_q == SRC_BRK) && cnt_q <= 3'd3) begin
                    src_d = SRC_NMI;
                end
`endif
                if (I_ready) begin
                    if (cnt_q == SEQ_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: vector table for reset/RES and IRQ flows, hand sequences for NMI, BRK, RDY and reset.
module tb_interrupt_sequencer;

    logic       I_clock = 1'b0;
    logic       I_reset = 1'b0;
    logic       I_nmi_n = 1'b1;
    logic       I_irq_n = 1'b1;
    logic       I_ready = 1'b1;
    logic       I_sync  = 1'b0;
    logic       I_brk   = 1'b0;
    logic       I_flag_i = 1'b0;
    logic       O_inject, O_busy, O_push_n, O_b_flag, O_set_i;
    logic [2:0] O_seq_cycle;
    logic [7:0] O_vector_lo;
    logic [2:0] pend;

    int n_cmp = 0;
    int n_bad = 0;

    interrupt_sequencer_if lif ();
    assign lif.I_pending = pend;

    interrupt_sequencer dut (
        .I_clock     (I_clock),
        .I_reset     (I_reset),
        .I_nmi_n     (I_nmi_n),
        .I_irq_n     (I_irq_n),
        .I_ready     (I_ready),
        .I_sync      (I_sync),
        .I_brk       (I_brk),
        .I_flag_i    (I_flag_i),
        .latch       (lif),
        .O_inject    (O_inject),
        .O_busy      (O_busy),
        .O_seq_cycle (O_seq_cycle),
        .O_push_n    (O_push_n),
        .O_b_flag    (O_b_flag),
        .O_set_i     (O_set_i),
        .O_vector_lo (O_vector_lo)
    );

    always #5 I_clock = ~I_clock;

    // Model of the external set/clear pending latch.
    always @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) pend <= 3'b000;
        else          pend <= (pend | lif.O_latch_set) & ~lif.O_latch_clear;
    end

    typedef struct {
        logic       sync, brk, flag_i, irq_n;
        logic [2:0] set, clr;
        logic       inj, busy;
        logic [2:0] seq;
        logic       push_n, b, set_i;
        logic [7:0] vec;
    } row_t;

    row_t tbl [26];

    function automatic row_t row(input logic s, input logic k, input logic f, input logic q,
                                 input logic [2:0] es, input logic [2:0] ec, input logic ei,
                                 input logic eb, input logic [2:0] eq, input logic ep,
                                 input logic ebf, input logic esi, input logic [7:0] ev);
        row_t r;
        r = '{s, k, f, q, es, ec, ei, eb, eq, ep, ebf, esi, ev};
        return r;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_clock);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk3({tag, ".set"},   lif.O_latch_set, 3'b000);
        chk3({tag, ".clr"},   lif.O_latch_clear, 3'b000);
        chk1({tag, ".inj"},   O_inject, 1'b0);
        chk1({tag, ".busy"},  O_busy, 1'b0);
        chk3({tag, ".seq"},   O_seq_cycle, 3'd0);
        chk1({tag, ".push"},  O_push_n, 1'b1);
        chk1({tag, ".b"},     O_b_flag, 1'b0);
        chk1({tag, ".seti"},  O_set_i, 1'b0);
        chk8({tag, ".vec"},   O_vector_lo, 8'hFE);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 20 && O_busy; k++) tick();
        chk1({tag, ".idle"}, O_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        int entries;

        //            sync brk flg irqn  set     clr     inj busy seq  push b  seti vec
        tbl[0]  = row(0, 0, 0, 1, 3'b001, 3'b100, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[1]  = row(0, 0, 0, 1, 3'b000, 3'b100, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[2]  = row(1, 0, 0, 1, 3'b000, 3'b100, 1, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[3]  = row(0, 0, 0, 1, 3'b000, 3'b100, 0, 1, 3'd0, 1, 0, 0, 8'hFC);
        tbl[4]  = row(0, 0, 0, 1, 3'b000, 3'b100, 0, 1, 3'd1, 1, 0, 0, 8'hFC);
        tbl[5]  = row(0, 0, 0, 1, 3'b000, 3'b100, 0, 1, 3'd2, 1, 0, 0, 8'hFC);
        tbl[6]  = row(0, 0, 0, 1, 3'b000, 3'b100, 0, 1, 3'd3, 1, 0, 0, 8'hFC);
        tbl[7]  = row(0, 0, 0, 1, 3'b000, 3'b100, 0, 1, 3'd4, 1, 0, 1, 8'hFC);
        tbl[8]  = row(0, 0, 0, 1, 3'b000, 3'b100, 0, 1, 3'd5, 1, 0, 0, 8'hFC);
        tbl[9]  = row(0, 0, 0, 1, 3'b000, 3'b101, 0, 1, 3'd6, 1, 0, 0, 8'hFC);
        tbl[10] = row(1, 0, 0, 1, 3'b000, 3'b100, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[11] = row(0, 0, 1, 0, 3'b000, 3'b100, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[12] = row(0, 0, 1, 0, 3'b000, 3'b100, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[13] = row(0, 0, 1, 0, 3'b000, 3'b100, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[14] = row(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[15] = row(0, 0, 0, 0, 3'b100, 3'b000, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[16] = row(1, 0, 0, 0, 3'b100, 3'b000, 1, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[17] = row(0, 0, 0, 0, 3'b100, 3'b000, 0, 1, 3'd0, 1, 0, 0, 8'hFE);
        tbl[18] = row(0, 0, 0, 0, 3'b100, 3'b000, 0, 1, 3'd1, 1, 0, 0, 8'hFE);
        tbl[19] = row(0, 0, 0, 0, 3'b100, 3'b000, 0, 1, 3'd2, 0, 0, 0, 8'hFE);
        tbl[20] = row(0, 0, 0, 0, 3'b100, 3'b000, 0, 1, 3'd3, 0, 0, 0, 8'hFE);
        tbl[21] = row(0, 0, 0, 0, 3'b100, 3'b000, 0, 1, 3'd4, 0, 0, 1, 8'hFE);
        tbl[22] = row(0, 0, 1, 0, 3'b100, 3'b000, 0, 1, 3'd5, 1, 0, 0, 8'hFE);
        tbl[23] = row(0, 0, 1, 0, 3'b000, 3'b100, 0, 1, 3'd6, 1, 0, 0, 8'hFE);
        tbl[24] = row(0, 0, 1, 0, 3'b000, 3'b000, 0, 0, 3'd0, 1, 0, 0, 8'hFE);
        tbl[25] = row(0, 0, 1, 1, 3'b000, 3'b000, 0, 0, 3'd0, 1, 0, 0, 8'hFE);

        repeat (3) @(posedge I_clock);
        @(negedge I_clock);
        check_reset_values("reset");
        @(posedge I_clock);
        #1 I_reset = 1'b1;

        // RES sequence after release, then an IRQ masked and unmasked by I_flag_i.
        for (int i = 0; i < 26; i++) begin
            tick();
            I_sync   = tbl[i].sync;
            I_brk    = tbl[i].brk;
            I_flag_i = tbl[i].flag_i;
            I_irq_n  = tbl[i].irq_n;
            @(negedge I_clock);
            chk3($sformatf("row%0d.set", i),  lif.O_latch_set, tbl[i].set);
            chk3($sformatf("row%0d.clr", i),  lif.O_latch_clear, tbl[i].clr);
            chk1($sformatf("row%0d.inj", i),  O_inject, tbl[i].inj);
            chk1($sformatf("row%0d.busy", i), O_busy, tbl[i].busy);
            chk3($sformatf("row%0d.seq", i),  O_seq_cycle, tbl[i].seq);
            chk1($sformatf("row%0d.push", i), O_push_n, tbl[i].push_n);
            chk1($sformatf("row%0d.b", i),    O_b_flag, tbl[i].b);
            chk1($sformatf("row%0d.seti", i), O_set_i, tbl[i].set_i);
            chk8($sformatf("row%0d.vec", i),  O_vector_lo, tbl[i].vec);
        end

        // NMI held low: one set pulse three clocks after the fall, one sequence only.
        tick();
        I_nmi_n = 1'b0;
        tick();
        @(negedge I_clock) chk3("nmi.set_p1", lif.O_latch_set, 3'b000);
        tick();
        @(negedge I_clock) chk3("nmi.set_p2", lif.O_latch_set, 3'b000);
        tick();
        @(negedge I_clock) chk3("nmi.set_p3", lif.O_latch_set, 3'b010);
        tick();
        I_sync = 1'b1;
        @(negedge I_clock);
        chk3("nmi.set_p4", lif.O_latch_set, 3'b000);
        chk1("nmi.inject", O_inject, 1'b1);
        pulses  = 0;
        entries = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (lif.O_latch_set[1]) pulses++;
            if (O_busy && O_seq_cycle == 3'd0) entries++;
            if (O_busy && O_seq_cycle == 3'd5) chk8("nmi.vec", O_vector_lo, 8'hFA);
            if (O_busy && O_seq_cycle == 3'd6) chk3("nmi.clr", lif.O_latch_clear, 3'b110);
        end
        chk1("nmi.no_repulse", pulses == 0, 1'b1);
        chk1("nmi.one_seq", entries == 1, 1'b1);
        I_sync  = 1'b0;
        I_nmi_n = 1'b1;
        repeat (4) tick();

        // BRK with an NMI arriving in the latch at sequence cycle 2.
        I_nmi_n = 1'b0;
        tick();
        I_sync = 1'b1;
        I_brk  = 1'b1;
        @(negedge I_clock) chk1("brk.inject", O_inject, 1'b0);
        tick();
        I_sync = 1'b0;
        I_brk  = 1'b0;
        @(negedge I_clock);
        chk1("brk.busy", O_busy, 1'b1);
        chk1("brk.b_seq0", O_b_flag, 1'b1);
        repeat (2) tick();
        @(negedge I_clock) chk1("brk.push_seq2", O_push_n, 1'b0);
        repeat (3) tick();
        @(negedge I_clock);
        chk3("brk.seq5", O_seq_cycle, 3'd5);
        chk1("brk.b_seq5", O_b_flag, 1'b1);
`ifdef NMI_HIJACK_EN
        chk8("brk.vec_hijack", O_vector_lo, 8'hFA);
        tick();
        @(negedge I_clock) chk3("brk.clr_hijack", lif.O_latch_clear, 3'b110);
        tick();
        I_sync = 1'b1;
        @(negedge I_clock) chk1("brk.no_second", O_inject, 1'b0);
        tick();
        I_sync = 1'b0;
        @(negedge I_clock) chk1("brk.stay_idle", O_busy, 1'b0);
`else
        chk8("brk.vec_frozen", O_vector_lo, 8'hFE);
        tick();
        @(negedge I_clock) chk3("brk.clr_none", lif.O_latch_clear, 3'b100);
        tick();
        I_sync = 1'b1;
        @(negedge I_clock) chk1("brk.nmi_next", O_inject, 1'b1);
        tick();
        I_sync = 1'b0;
        repeat (5) tick();
        @(negedge I_clock);
        chk8("brk.nmi_vec", O_vector_lo, 8'hFA);
        chk1("brk.nmi_b", O_b_flag, 1'b0);
        wait_idle("brk_nmi");
`endif
        I_nmi_n = 1'b1;
        repeat (4) tick();

        // RDY low for three cycles in sequence cycle 4.
        I_sync = 1'b1;
        I_brk  = 1'b1;
        tick();
        I_sync = 1'b0;
        I_brk  = 1'b0;
        repeat (4) tick();
        I_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            @(negedge I_clock);
            chk3($sformatf("rdy.hold%0d.seq", k), O_seq_cycle, 3'd4);
            chk1($sformatf("rdy.hold%0d.seti", k), O_set_i, 1'b0);
        end
        tick();
        I_ready = 1'b1;
        @(negedge I_clock);
        chk3("rdy.resume.seq", O_seq_cycle, 3'd4);
        chk1("rdy.resume.seti", O_set_i, 1'b1);
        tick();
        @(negedge I_clock);
        chk3("rdy.next.seq", O_seq_cycle, 3'd5);
        chk1("rdy.next.seti", O_set_i, 1'b0);
        wait_idle("rdy");
        repeat (2) tick();

        // Reset asserted at sequence cycle 3, then the RES sequence.
        I_sync = 1'b1;
        I_brk  = 1'b1;
        tick();
        I_sync = 1'b0;
        I_brk  = 1'b0;
        repeat (3) tick();
        @(negedge I_clock) chk1("rst.push_before", O_push_n, 1'b0);
        #2 I_reset = 1'b0;
        #1 check_reset_values("rst_async");
        @(posedge I_clock);
        @(posedge I_clock);
        #1 I_reset = 1'b1;
        tick();
        @(negedge I_clock) chk3("rst.res_set", lif.O_latch_set, 3'b001);
        tick();
        I_sync = 1'b1;
        @(negedge I_clock) chk1("rst.inject", O_inject, 1'b1);
        tick();
        I_sync = 1'b0;
        repeat (2) tick();
        @(negedge I_clock) chk1("rst.push_seq2", O_push_n, 1'b1);
        repeat (3) tick();
        @(negedge I_clock) chk8("rst.vec", O_vector_lo, 8'hFC);
        wait_idle("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
